// File: rtl/sm4_pkg.sv
// Shared SM4 constants (FK, CK, S-box), FSM state encoding and a rotate helper
// used by the on-the-fly decryption core.
package sm4_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        READY = 3'd2,
        DEC   = 3'd3,
        HOLD  = 3'd4
    } state_t;

    localparam logic [31:0] FK0 = 32'ha3b1bac6;
    localparam logic [31:0] FK1 = 32'h56aa3350;
    localparam logic [31:0] FK2 = 32'h677d9197;
    localparam logic [31:0] FK3 = 32'hb27022dc;
    localparam logic [31:0] FK [4] = '{FK0, FK1, FK2, FK3};

    localparam logic [31:0] CK [32] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [31:0] rotl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

endpackage

// File: rtl/sm4_round.sv
// One SM4 round function y = a ^ L(tau(b)); KEY_MODE selects the key-schedule
// linear transform L' instead of the cipher transform L.
module sm4_round
    import sm4_pkg::*;
#(
    parameter bit KEY_MODE = 1'b0
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0] s;
    logic [31:0] l;

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign s[gi*8 +: 8] = SBOX[b[gi*8 +: 8]];
    end

    if (KEY_MODE) begin : g_key
        assign l = s ^ rotl(s, 13) ^ rotl(s, 23);
    end else begin : g_cipher
        assign l = s ^ rotl(s, 2) ^ rotl(s, 10) ^ rotl(s, 18) ^ rotl(s, 24);
    end

    assign y = a ^ l;

endmodule

// File: rtl/sm4_dec_otf.sv
// SM4 block decryptor with on-the-fly round keys: the forward schedule is run
// once per key, then each block rolls the key state backwards alongside the data.
module sm4_dec_otf
    import sm4_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [31:0] MK0,
    input  logic [31:0] MK1,
    input  logic [31:0] MK2,
    input  logic [31:0] MK3,
    output logic        key_rdy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] X0,
    input  logic [31:0] X1,
    input  logic [31:0] X2,
    input  logic [31:0] X3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Y0,
    output logic [31:0] Y1,
    output logic [31:0] Y2,
    output logic [31:0] Y3
);

    state_t      state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] data_reg [4];
    logic [31:0] wk_reg   [4];
    logic [31:0] fk_reg   [4];
    logic [31:0] y_reg    [4];
    logic        key_rdy_reg;
    logic        out_valid_reg;

    logic [31:0] mk_word [4];
    logic [31:0] x_word  [4];
    logic [31:0] key_a;
    logic [31:0] key_b;
    logic [31:0] key_new;
    logic [31:0] dat_b;
    logic [31:0] dat_new;

    assign mk_word[0] = MK0;
    assign mk_word[1] = MK1;
    assign mk_word[2] = MK2;
    assign mk_word[3] = MK3;
    assign x_word[0]  = X0;
    assign x_word[1]  = X1;
    assign x_word[2]  = X2;
    assign x_word[3]  = X3;

    // One key-mode round serves both directions: forward in KEXP, backward in DEC
    // where round j needs CK[31-j], i.e. the bitwise inverse of the 5-bit counter.
    always_comb begin
        key_a = wk_reg[0];
        key_b = wk_reg[1] ^ wk_reg[2] ^ wk_reg[3] ^ CK[cnt_reg];
        if (state_reg == DEC) begin
            key_a = wk_reg[3];
            key_b = wk_reg[0] ^ wk_reg[1] ^ wk_reg[2] ^ CK[~cnt_reg];
        end
    end

    assign dat_b = data_reg[1] ^ data_reg[2] ^ data_reg[3] ^ wk_reg[3];

    sm4_round #(.KEY_MODE(1'b1)) u_key_round (
        .a (key_a),
        .b (key_b),
        .y (key_new)
    );

    sm4_round #(.KEY_MODE(1'b0)) u_data_round (
        .a (data_reg[0]),
        .b (dat_b),
        .y (dat_new)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            key_rdy_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                data_reg[i] <= '0;
                wk_reg[i]   <= '0;
                fk_reg[i]   <= '0;
                y_reg[i]    <= '0;
            end
        end else begin
            case (state_reg)
                IDLE, READY: begin
                    if (key_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            wk_reg[i] <= mk_word[i] ^ FK[i];
                        end
                        key_rdy_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= KEXP;
                    end else if (state_reg == READY && in_valid) begin
                        for (int i = 0; i < 4; i++) begin
                            data_reg[i] <= x_word[i];
                            wk_reg[i]   <= fk_reg[i];
                        end
                        cnt_reg   <= '0;
                        state_reg <= DEC;
                    end
                end
                KEXP: begin
                    wk_reg[0] <= wk_reg[1];
                    wk_reg[1] <= wk_reg[2];
                    wk_reg[2] <= wk_reg[3];
                    wk_reg[3] <= key_new;
                    cnt_reg   <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        fk_reg[0]   <= wk_reg[1];
                        fk_reg[1]   <= wk_reg[2];
                        fk_reg[2]   <= wk_reg[3];
                        fk_reg[3]   <= key_new;
                        key_rdy_reg <= 1'b1;
                        state_reg   <= READY;
                    end
                end
                DEC: begin
                    data_reg[0] <= data_reg[1];
                    data_reg[1] <= data_reg[2];
                    data_reg[2] <= data_reg[3];
                    data_reg[3] <= dat_new;
                    // Key words move down; the recovered older word enters at the bottom.
                    wk_reg[0]   <= key_new;
                    wk_reg[1]   <= wk_reg[0];
                    wk_reg[2]   <= wk_reg[1];
                    wk_reg[3]   <= wk_reg[2];
                    cnt_reg     <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        y_reg[0]      <= dat_new;
                        y_reg[1]      <= data_reg[3];
                        y_reg[2]      <= data_reg[2];
                        y_reg[3]      <= data_reg[1];
                        out_valid_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= READY;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign key_ready = (state_reg == IDLE) || (state_reg == READY);
    assign in_ready  = (state_reg == READY);
    assign key_rdy   = key_rdy_reg;
    assign out_valid = out_valid_reg;
    assign Y0        = y_reg[0];
    assign Y1        = y_reg[1];
    assign Y2        = y_reg[2];
    assign Y3        = y_reg[3];

endmodule

// File: tb/tb_sm4_dec_otf.sv
// Scoreboard bench for sm4_dec_otf: stimulus pushes expected plaintexts from a
// plain SM4 reference model; a negedge monitor compares every presented block.
module tb_sm4_dec_otf;
    import sm4_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [31:0] MK0 = '0, MK1 = '0, MK2 = '0, MK3 = '0;
    logic        key_rdy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] X0 = '0, X1 = '0, X2 = '0, X3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] Y0, Y1, Y2, Y3;

    sm4_dec_otf dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .MK0       (MK0),
        .MK1       (MK1),
        .MK2       (MK2),
        .MK3       (MK3),
        .key_rdy   (key_rdy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X0        (X0),
        .X1        (X1),
        .X2        (X2),
        .X3        (X3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y0        (Y0),
        .Y1        (Y1),
        .Y2        (Y2),
        .Y3        (Y3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] pt;
        int           rise;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_i(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- reference model: plain SM4 from the algorithm definition
    function automatic logic [31:0] m_rotl(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [31:0] m_tau(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = SBOX[w[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [31:0] m_ck(input int i);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
        return r;
    endfunction

    function automatic logic [127:0] ref_dec(input logic [127:0] key, input logic [127:0] ct);
        logic [31:0] k [36];
        logic [31:0] x [36];
        logic [31:0] fkc [4];
        logic [31:0] t;
        fkc[0] = 32'ha3b1bac6; fkc[1] = 32'h56aa3350;
        fkc[2] = 32'h677d9197; fkc[3] = 32'hb27022dc;
        for (int i = 0; i < 4; i++) begin
            k[i] = key[127-32*i -: 32] ^ fkc[i];
            x[i] = ct[127-32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            t = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ m_ck(i));
            k[i+4] = k[i] ^ t ^ m_rotl(t, 13) ^ m_rotl(t, 23);
        end
        for (int i = 0; i < 32; i++) begin
            t = m_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[35-i]);
            x[i+4] = x[i] ^ t ^ m_rotl(t, 2) ^ m_rotl(t, 10) ^ m_rotl(t, 18) ^ m_rotl(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- monitor
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            ov_prev <= 1'b0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_i("unexpected_out_valid", 1, 0);
                end else begin
                    if (!ov_prev) check_i("out_valid_latency", cyc, sb_q[0].rise);
                    check_w("plaintext", {Y0, Y1, Y2, Y3}, sb_q[0].pt);
                    check_i("in_ready_in_hold", int'(in_ready), 0);
                    if (out_ready) begin
                        $display("OUT  cycle %0d Y=%h", cyc, {Y0, Y1, Y2, Y3});
                        void'(sb_q.pop_front());
                    end
                end
            end
            ov_prev <= out_valid;
        end
    end

    // ---------------- drivers
    task automatic load_key(input logic [127:0] k, output int kcyc);
        @(negedge clk);
        {MK0, MK1, MK2, MK3} = k;
        key_valid = 1'b1;
        kcyc = -1;
        for (int i = 0; i < 200 && kcyc < 0; i++) begin
            if (key_ready) kcyc = cyc;
            else @(negedge clk);
        end
        if (kcyc < 0) check_i("key_accept_timeout", 0, 1);
        @(posedge clk);
        #1 key_valid = 1'b0;
        $display("KEY  cycle %0d K=%h", kcyc, k);
        check_i("key_rdy_drop", int'(key_rdy), 0);
        check_i("in_ready_in_kexp", int'(in_ready), 0);
    endtask

    task automatic wait_key_rdy(input int kcyc);
        int i;
        for (i = 0; i < 100 && !key_rdy; i++) @(negedge clk);
        if (!key_rdy) check_i("key_rdy_timeout", 0, 1);
        else check_i("key_rdy_latency", cyc - kcyc, 33);
    endtask

    task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, output int tcyc);
        exp_t e;
        @(negedge clk);
        {X0, X1, X2, X3} = ct;
        in_valid = 1'b1;
        tcyc = -1;
        for (int i = 0; i < 300 && tcyc < 0; i++) begin
            if (in_ready) tcyc = cyc;
            else @(negedge clk);
        end
        if (tcyc < 0) begin
            check_i("in_accept_timeout", 0, 1);
        end else begin
            e.pt = pt;
            e.rise = tcyc + 33;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        $display("IN   cycle %0d C=%h", tcyc, ct);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
        check_i("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;
    localparam logic [127:0] KAT_PT  = 128'h0123456789abcdeffedcba9876543210;

    initial begin
        int kc, tc, t1, t2, t3;
        logic [127:0] k2, c2;

        // reset behaviour
        repeat (3) @(negedge clk);
        check_w("reset_Y", {Y0, Y1, Y2, Y3}, '0);
        check_i("reset_out_valid", int'(out_valid), 0);
        check_i("reset_key_rdy", int'(key_rdy), 0);
        rst = 1'b1;
        @(negedge clk);
        check_i("post_reset_key_ready", int'(key_ready), 1);
        check_i("post_reset_in_ready", int'(in_ready), 0);

        // known-answer vector
        load_key(KAT_KEY, kc);
        wait_key_rdy(kc);
        send_block(KAT_CT, KAT_PT, tc);
        wait_drain();

        // three back-to-back blocks under the same key
        send_block(KAT_CT, KAT_PT, t1);
        send_block(KAT_CT, KAT_PT, t2);
        send_block(KAT_CT, KAT_PT, t3);
        check_i("b2b_spacing_1", t2 - t1, 34);
        check_i("b2b_spacing_2", t3 - t2, 34);
        wait_drain();

        // back-pressure: hold out_ready low for 10 cycles
        @(posedge clk);
        #1 out_ready = 1'b0;
        c2 = {$urandom, $urandom, $urandom, $urandom};
        send_block(c2, ref_dec(KAT_KEY, c2), tc);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check_i("hold_out_valid", int'(out_valid), 1);
            check_i("hold_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_i("release_in_ready", int'(in_ready), 1);
        check_i("release_out_valid", int'(out_valid), 0);
        wait_drain();

        // key reload in READY, ciphertext presented at once
        k2 = {$urandom, $urandom, $urandom, $urandom};
        c2 = {$urandom, $urandom, $urandom, $urandom};
        load_key(k2, kc);
        send_block(c2, ref_dec(k2, c2), tc);
        check_i("reload_accept_cycle", tc - kc, 33);
        check_i("reload_key_rdy", int'(key_rdy), 1);
        wait_drain();

        // key_valid and in_valid together: key wins
        k2 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        {MK0, MK1, MK2, MK3} = k2;
        {X0, X1, X2, X3} = KAT_CT;
        key_valid = 1'b1;
        in_valid = 1'b1;
        kc = cyc;
        @(posedge clk);
        #1 key_valid = 1'b0;
        in_valid = 1'b0;
        $display("KEY  cycle %0d K=%h (with in_valid)", kc, k2);
        @(negedge clk);
        check_i("collide_in_ready", int'(in_ready), 0);
        check_i("collide_key_rdy", int'(key_rdy), 0);
        wait_key_rdy(kc);
        repeat (40) @(negedge clk);
        check_i("collide_no_output", sb_q.size(), 0);
        for (int b = 0; b < 2; b++) begin
            c2 = {$urandom, $urandom, $urandom, $urandom};
            send_block(c2, ref_dec(k2, c2), tc);
        end
        wait_drain();

        // reset in the middle of DEC round 15
        c2 = {$urandom, $urandom, $urandom, $urandom};
        send_block(c2, ref_dec(k2, c2), tc);
        while (cyc < tc + 16) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_w("midrst_Y", {Y0, Y1, Y2, Y3}, '0);
        check_i("midrst_out_valid", int'(out_valid), 0);
        check_i("midrst_key_rdy", int'(key_rdy), 0);
        check_i("midrst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        load_key(KAT_KEY, kc);
        wait_key_rdy(kc);
        send_block(KAT_CT, KAT_PT, tc);
        wait_drain();

        // random keys and blocks
        for (int k = 0; k < 2; k++) begin
            k2 = {$urandom, $urandom, $urandom, $urandom};
            load_key(k2, kc);
            wait_key_rdy(kc);
            for (int b = 0; b < 2; b++) begin
                c2 = {$urandom, $urandom, $urandom, $urandom};
                send_block(c2, ref_dec(k2, c2), tc);
            end
            wait_drain();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
